// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: MIPS opcode/funct values, instruction
// classes, bypass selects, Tnew/Tuse constants and multiply/divide busy latencies.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [3:0] {
    CL_NOP, CL_CAL_R, CL_CAL_I, CL_LOAD, CL_STORE, CL_BEQ,
    CL_J, CL_JAL, CL_JR, CL_MD, CL_MF, CL_MT
  } cls_e;

  typedef enum logic [1:0] {SRC_ALU, SRC_DM, SRC_PC8} src_e;

  localparam logic [2:0] SEL_RF    = 3'd0;
  localparam logic [2:0] SEL_WD    = 3'd1;
  localparam logic [2:0] SEL_PC8_M = 3'd2;
  localparam logic [2:0] SEL_ALU_M = 3'd3;
  localparam logic [2:0] SEL_PC8_E = 3'd4;

  localparam logic [1:0] TNEW_JAL  = 2'd0;
  localparam logic [1:0] TNEW_CAL  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] TUSE_BR    = 2'd0;
  localparam logic [1:0] TUSE_CAL   = 2'd1;
  localparam logic [1:0] TUSE_ST_RT = 2'd2;
  localparam logic [1:0] TUSE_NONE  = 2'd3;

  localparam logic [3:0] MD_LAT_MULT = 4'd5;
  localparam logic [3:0] MD_LAT_DIV  = 4'd10;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [4:0] dest;
    logic [1:0] tnew;
    src_e       src;
  } stage_t;

  localparam stage_t BUBBLE = '{dest: 5'd0, tnew: 2'd0, src: SRC_ALU};

  // rs/rt are zero when the class does not read that register.
  typedef struct packed {
    cls_e       cls;
    logic       is_div;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    stage_t     st;
  } dec_t;

  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of one instruction into hazard-relevant attributes.
// Zero latency; unknown encodings decode as a nop with no register use.
module instr_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] i_ir,
  output dec_t        o_dec
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_sh0;

  assign w_op  = i_ir[31:26];
  assign w_rs  = i_ir[25:21];
  assign w_rt  = i_ir[20:16];
  assign w_rd  = i_ir[15:11];
  assign w_fn  = i_ir[5:0];
  assign w_sh0 = (i_ir[10:6] == 5'd0);

  always_comb begin
    o_dec         = '0;
    o_dec.cls     = CL_NOP;
    o_dec.tuse_rs = TUSE_NONE;
    o_dec.tuse_rt = TUSE_NONE;
    o_dec.st      = BUBBLE;
    case (w_op)
      OP_SPECIAL: begin
        if (w_sh0) begin
          case (w_fn)
            FN_ADDU, FN_SUBU: begin
              o_dec.cls     = CL_CAL_R;
              o_dec.rs      = w_rs;
              o_dec.rt      = w_rt;
              o_dec.tuse_rs = TUSE_CAL;
              o_dec.tuse_rt = TUSE_CAL;
              o_dec.st      = '{dest: w_rd, tnew: TNEW_CAL, src: SRC_ALU};
            end
            FN_JR: begin
              o_dec.cls     = CL_JR;
              o_dec.rs      = w_rs;
              o_dec.tuse_rs = TUSE_BR;
            end
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
              o_dec.cls     = CL_MD;
              o_dec.is_div  = (w_fn == FN_DIV) || (w_fn == FN_DIVU);
              o_dec.rs      = w_rs;
              o_dec.rt      = w_rt;
              o_dec.tuse_rs = TUSE_CAL;
              o_dec.tuse_rt = TUSE_CAL;
            end
            FN_MFHI, FN_MFLO: begin
              o_dec.cls = CL_MF;
              o_dec.st  = '{dest: w_rd, tnew: TNEW_CAL, src: SRC_ALU};
            end
            FN_MTHI, FN_MTLO: begin
              o_dec.cls     = CL_MT;
              o_dec.rs      = w_rs;
              o_dec.tuse_rs = TUSE_CAL;
            end
            default: ;
          endcase
        end
      end
      OP_ORI, OP_LUI: begin
        o_dec.cls     = CL_CAL_I;
        o_dec.rs      = w_rs;
        o_dec.tuse_rs = TUSE_CAL;
        o_dec.st      = '{dest: w_rt, tnew: TNEW_CAL, src: SRC_ALU};
      end
      OP_LW: begin
        o_dec.cls     = CL_LOAD;
        o_dec.rs      = w_rs;
        o_dec.tuse_rs = TUSE_CAL;
        o_dec.st      = '{dest: w_rt, tnew: TNEW_LOAD, src: SRC_DM};
      end
      OP_SW: begin
        o_dec.cls     = CL_STORE;
        o_dec.rs      = w_rs;
        o_dec.rt      = w_rt;
        o_dec.tuse_rs = TUSE_CAL;
        o_dec.tuse_rt = TUSE_ST_RT;
      end
      OP_BEQ: begin
        o_dec.cls     = CL_BEQ;
        o_dec.rs      = w_rs;
        o_dec.rt      = w_rt;
        o_dec.tuse_rs = TUSE_BR;
        o_dec.tuse_rt = TUSE_BR;
      end
      OP_J:   o_dec.cls = CL_J;
      OP_JAL: begin
        o_dec.cls = CL_JAL;
        o_dec.st  = '{dest: REG_RA, tnew: TNEW_JAL, src: SRC_PC8};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bypass control for a 5-stage MIPS pipeline using a shadow E/M/W register chain.
// Stall and selects are combinational from ir_d and the shadow state; mult/div busy adds 5/10 cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  output logic        stall,
  output logic [2:0]  rsd_sel,
  output logic [2:0]  rtd_sel,
  output logic [2:0]  rse_sel,
  output logic [2:0]  rte_sel,
  output logic [2:0]  rtm_sel,
  output logic [4:0]  a3_w
);

  dec_t       w_dec;
  stage_t     r_e, r_m, r_w;
  logic [4:0] r_e_rs, r_e_rt, r_m_rt;
  logic       r_e_md, r_e_div;
  logic [3:0] r_busy_cnt;
  logic       w_d_md, w_stall_rs, w_stall_rt, w_stall_md;
  logic       w_e_pc8, w_w_rdy;
  logic [2:0] w_m_sel;
  logic       w_unused;

  instr_decode u_decode (
    .i_ir  (ir_d),
    .o_dec (w_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_e        <= BUBBLE;
      r_m        <= BUBBLE;
      r_w        <= BUBBLE;
      r_e_rs     <= 5'd0;
      r_e_rt     <= 5'd0;
      r_m_rt     <= 5'd0;
      r_e_md     <= 1'b0;
      r_e_div    <= 1'b0;
      r_busy_cnt <= 4'd0;
    end else begin
      r_m    <= '{dest: r_e.dest, tnew: tnew_dec(r_e.tnew), src: r_e.src};
      r_w    <= '{dest: r_m.dest, tnew: tnew_dec(r_m.tnew), src: r_m.src};
      r_m_rt <= r_e_rt;
      if (stall) begin
        r_e     <= BUBBLE;
        r_e_rs  <= 5'd0;
        r_e_rt  <= 5'd0;
        r_e_md  <= 1'b0;
        r_e_div <= 1'b0;
      end else begin
        r_e     <= w_dec.st;
        r_e_rs  <= w_dec.rs;
        r_e_rt  <= w_dec.rt;
        r_e_md  <= (w_dec.cls == CL_MD);
        r_e_div <= w_dec.is_div;
      end
      // The md unit starts when the instruction leaves E.
      if (r_e_md) begin
        r_busy_cnt <= r_e_div ? MD_LAT_DIV : MD_LAT_MULT;
      end else if (r_busy_cnt != 4'd0) begin
        r_busy_cnt <= r_busy_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_stall_rs = (w_dec.rs != 5'd0) &&
                 (((r_e.dest == w_dec.rs) && (r_e.tnew > w_dec.tuse_rs)) ||
                  ((r_m.dest == w_dec.rs) && (r_m.tnew > w_dec.tuse_rs)));
    w_stall_rt = (w_dec.rt != 5'd0) &&
                 (((r_e.dest == w_dec.rt) && (r_e.tnew > w_dec.tuse_rt)) ||
                  ((r_m.dest == w_dec.rt) && (r_m.tnew > w_dec.tuse_rt)));
    w_d_md     = w_dec.cls inside {CL_MD, CL_MF, CL_MT};
    w_stall_md = w_d_md && (r_e_md || (r_busy_cnt != 4'd0));
    stall      = w_stall_rs || w_stall_rt || w_stall_md;
  end

  always_comb begin
    w_m_sel = SEL_RF;
    if (r_m.tnew == 2'd0) begin
      case (r_m.src)
        SRC_PC8: w_m_sel = SEL_PC8_M;
        SRC_ALU: w_m_sel = SEL_ALU_M;
        default: w_m_sel = SEL_RF;
      endcase
    end
  end

  assign w_e_pc8  = (r_e.tnew == 2'd0) && (r_e.src == SRC_PC8);
  assign w_w_rdy  = (r_w.tnew == 2'd0);
  assign w_unused = ^r_w.src;

  // Newest producing stage wins; a zero register never matches, so bubbles never forward.
  function automatic logic [2:0] pick(input logic [4:0] r,
                                      input logic [4:0] e_dest, input logic e_pc8,
                                      input logic [4:0] m_dest, input logic [2:0] m_sel,
                                      input logic [4:0] w_dest, input logic w_rdy);
    if (r == 5'd0)                              return SEL_RF;
    else if ((e_dest == r) && e_pc8)            return SEL_PC8_E;
    else if ((m_dest == r) && (m_sel != SEL_RF)) return m_sel;
    else if ((w_dest == r) && w_rdy)            return SEL_WD;
    else                                        return SEL_RF;
  endfunction

  assign rsd_sel = pick(w_dec.rs, r_e.dest, w_e_pc8, r_m.dest, w_m_sel, r_w.dest, w_w_rdy);
  assign rtd_sel = pick(w_dec.rt, r_e.dest, w_e_pc8, r_m.dest, w_m_sel, r_w.dest, w_w_rdy);
  assign rse_sel = pick(r_e_rs, 5'd0, 1'b0, r_m.dest, w_m_sel, r_w.dest, w_w_rdy);
  assign rte_sel = pick(r_e_rt, 5'd0, 1'b0, r_m.dest, w_m_sel, r_w.dest, w_w_rdy);
  assign rtm_sel = ((r_m_rt != 5'd0) && (r_w.dest == r_m_rt) && w_w_rdy) ? SEL_WD : SEL_RF;
  assign a3_w    = r_w.dest;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each cycle's expected outputs are queued with the stimulus
// and popped for comparison mid-cycle.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] ir_d;
  logic        stall;
  logic [2:0]  rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel;
  logic [4:0]  a3_w;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [4:0] v [7];
  } exp_t;

  exp_t  sb [$];
  string names [7] = '{"stall", "rsd_sel", "rtd_sel", "rse_sel", "rte_sel", "rtm_sel", "a3_w"};

  hazard_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .ir_d    (ir_d),
    .stall   (stall),
    .rsd_sel (rsd_sel),
    .rtd_sel (rtd_sel),
    .rse_sel (rse_sel),
    .rte_sel (rte_sel),
    .rtm_sel (rtm_sel),
    .a3_w    (a3_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [4:0] st, input logic [4:0] rsd,
                      input logic [4:0] rtd, input logic [4:0] rse, input logic [4:0] rte,
                      input logic [4:0] rtm, input logic [4:0] a3);
    exp_t x;
    x.tag = tag;
    x.v   = '{st, rsd, rtd, rse, rte, rtm, a3};
    sb.push_back(x);
  endtask

  task automatic compare();
    exp_t       x;
    logic [4:0] obs [7];
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    x   = sb.pop_front();
    obs = '{{4'd0, stall}, {2'd0, rsd_sel}, {2'd0, rtd_sel}, {2'd0, rse_sel},
            {2'd0, rte_sel}, {2'd0, rtm_sel}, a3_w};
    for (int i = 0; i < 7; i++) chk({x.tag, ".", names[i]}, obs[i], x.v[i]);
  endtask

  // One pipeline cycle: drive D, queue the expectation, check at the falling edge.
  task automatic step(input string tag, input logic [31:0] ir, input logic [4:0] st,
                      input logic [4:0] rsd, input logic [4:0] rtd, input logic [4:0] rse,
                      input logic [4:0] rte, input logic [4:0] rtm, input logic [4:0] a3);
    ir_d = ir;
    push(tag, st, rsd, rtd, rse, rte, rtm, a3);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] nop_i, lw1, addu2_11, ori3, beq33, jal_i, jr31, mult12, div12, mflo4;
    logic [31:0] lw5, sw5, addu0_11, addu2_00, addu6_11, addu7_66;
    nop_i    = 32'h0000_0000;
    lw1      = itype(6'h23, 5'd0, 5'd1, 16'h0000);
    addu2_11 = rtype(5'd1, 5'd1, 5'd2, 6'h21);
    ori3     = itype(6'h0d, 5'd0, 5'd3, 16'h0005);
    beq33    = itype(6'h04, 5'd3, 5'd3, 16'h0000);
    jal_i    = {6'h03, 26'h000_0100};
    jr31     = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    mult12   = rtype(5'd1, 5'd2, 5'd0, 6'h18);
    div12    = rtype(5'd1, 5'd2, 5'd0, 6'h1a);
    mflo4    = rtype(5'd0, 5'd0, 5'd4, 6'h12);
    lw5      = itype(6'h23, 5'd0, 5'd5, 16'h0000);
    sw5      = itype(6'h2b, 5'd0, 5'd5, 16'h0000);
    addu0_11 = rtype(5'd1, 5'd1, 5'd0, 6'h21);
    addu2_00 = rtype(5'd0, 5'd0, 5'd2, 6'h21);
    addu6_11 = rtype(5'd1, 5'd1, 5'd6, 6'h21);
    addu7_66 = rtype(5'd6, 5'd6, 5'd7, 6'h21);

    reset = 1'b1;
    ir_d  = 32'h0;
    @(posedge clk);
    #1;
    step("rst", lw1, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // load-use: one stall, then W-stage bypass into E
    step("lu1", lw1,      0, 0, 0, 0, 0, 0, 0);
    step("lu2", addu2_11, 1, 0, 0, 0, 0, 0, 0);
    step("lu3", addu2_11, 0, 0, 0, 0, 0, 0, 0);
    step("lu4", nop_i,    0, 0, 0, 1, 1, 0, 1);
    step("lu5", nop_i,    0, 0, 0, 0, 0, 0, 0);
    step("lu6", nop_i,    0, 0, 0, 0, 0, 0, 2);
    step("lu7", nop_i,    0, 0, 0, 0, 0, 0, 0);

    // ALU result into a branch comparator
    step("br1", ori3,  0, 0, 0, 0, 0, 0, 0);
    step("br2", beq33, 1, 0, 0, 0, 0, 0, 0);
    step("br3", beq33, 0, 3, 3, 0, 0, 0, 0);
    step("br4", nop_i, 0, 0, 0, 1, 1, 0, 3);
    step("br5", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("br6", nop_i, 0, 0, 0, 0, 0, 0, 0);

    // jal link value into jr: from E, then from M
    step("ja1", jal_i, 0, 0, 0, 0, 0, 0, 0);
    step("ja2", jr31,  0, 4, 0, 0, 0, 0, 0);
    step("ja3", nop_i, 0, 0, 0, 2, 0, 0, 0);
    step("ja4", nop_i, 0, 0, 0, 0, 0, 0, 31);
    step("ja5", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("jb1", jal_i, 0, 0, 0, 0, 0, 0, 0);
    step("jb2", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("jb3", jr31,  0, 2, 0, 0, 0, 0, 0);
    step("jb4", nop_i, 0, 0, 0, 1, 0, 0, 31);
    step("jb5", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("jb6", nop_i, 0, 0, 0, 0, 0, 0, 0);

    // mult then mflo: 6 stall cycles
    step("mu0", mult12, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step($sformatf("mu_st%0d", i), mflo4, 1, 0, 0, 0, 0, 0, 0);
    step("mu7", mflo4, 0, 0, 0, 0, 0, 0, 0);
    step("mu8", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("mu9", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("mua", nop_i, 0, 0, 0, 0, 0, 0, 4);
    step("mub", nop_i, 0, 0, 0, 0, 0, 0, 0);

    // div then mflo: 11 stall cycles
    step("dv0", div12, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step($sformatf("dv_st%0d", i), mflo4, 1, 0, 0, 0, 0, 0, 0);
    step("dv1", mflo4, 0, 0, 0, 0, 0, 0, 0);
    step("dv2", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("dv3", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("dv4", nop_i, 0, 0, 0, 0, 0, 0, 4);
    step("dv5", nop_i, 0, 0, 0, 0, 0, 0, 0);

    // load feeding store data: no stall, bypass at M
    step("st1", lw5,   0, 0, 0, 0, 0, 0, 0);
    step("st2", sw5,   0, 0, 0, 0, 0, 0, 0);
    step("st3", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("st4", nop_i, 0, 0, 0, 0, 0, 1, 5);
    step("st5", nop_i, 0, 0, 0, 0, 0, 0, 0);

    // writes to $0 never forward
    step("z1", addu0_11, 0, 0, 0, 0, 0, 0, 0);
    step("z2", addu2_00, 0, 0, 0, 0, 0, 0, 0);
    step("z3", nop_i,    0, 0, 0, 0, 0, 0, 0);
    step("z4", nop_i,    0, 0, 0, 0, 0, 0, 0);
    step("z5", nop_i,    0, 0, 0, 0, 0, 0, 2);
    step("z6", nop_i,    0, 0, 0, 0, 0, 0, 0);

    // ALU result one ahead: no stall, M-stage bypass into E, then rt match at M
    step("al1", addu6_11, 0, 0, 0, 0, 0, 0, 0);
    step("al2", addu7_66, 0, 0, 0, 0, 0, 0, 0);
    step("al3", nop_i,    0, 0, 0, 3, 3, 0, 0);
    step("al4", nop_i,    0, 0, 0, 0, 0, 1, 6);
    step("al5", nop_i,    0, 0, 0, 0, 0, 0, 7);
    step("al6", nop_i,    0, 0, 0, 0, 0, 0, 0);

    // reset asserted three cycles into a div stall
    step("rd0", div12, 0, 0, 0, 0, 0, 0, 0);
    step("rd1", mflo4, 1, 0, 0, 0, 0, 0, 0);
    step("rd2", mflo4, 1, 0, 0, 0, 0, 0, 0);
    step("rd3", mflo4, 1, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    push("rd_async", 0, 0, 0, 0, 0, 0, 0);
    #2;
    compare();
    @(posedge clk);
    #1;
    step("rd_hold", mflo4, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step("rd4", mflo4, 0, 0, 0, 0, 0, 0, 0);
    step("rd5", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("rd6", nop_i, 0, 0, 0, 0, 0, 0, 0);
    step("rd7", nop_i, 0, 0, 0, 0, 0, 0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port ir_d  input  32  instruction currently held in the F/D register.
REQ-004 SHALL have port stall  output  1  freezes PC and F/D; D/E captures a bubble.
REQ-005 SHALL have ports rsd_sel, rtd_sel  output  3  D-stage bypass selects: 0 RF, 1 wdata, 2 pc8_m, 3 aluout_m, 4 pc8_e.
REQ-006 SHALL have ports rse_sel, rte_sel  output  3  E-stage bypass selects: 0 D/E value, 1 wdata, 2 pc8_m, 3 aluout_m.
REQ-007 SHALL have port rtm_sel  output  3  M-stage store-data select: 0 E/M value, 1 wdata.
REQ-008 SHALL have port a3_w  output  5  RF write address of the W-stage instruction; 0 means no write.

Function
REQ-009 SHALL decode ir_d into these classes:
- cal_r: addu, subu
- cal_i: ori, lui
- load: lw
- store: sw
- beq, j, jal, jr, nop
- md: mult, multu, div, divu
- mf: mfhi, mflo
- mt: mthi, mtlo
REQ-010 SHALL decode any unrecognised encoding as nop: no destination, no register use.
REQ-011 SHALL assign destinations: cal_r and mf use rd; cal_i and load use rt; jal uses 31; all other classes have no destination (0).
REQ-012 SHALL assign Tnew at E: load 2; cal_r, cal_i, mf 1; jal 0, with result source pc8.
REQ-013 SHALL assign Tuse: beq rs/rt 0; jr rs 0; cal, load, md, mt rs 1; cal_r and md rt 1; store rs 1, rt 2.
REQ-014 SHALL hold a shadow pipeline E→M→W of {dest[4:0], tnew[1:0], src ∈ alu/dm/pc8}.
REQ-015 Each cycle, M←E and W←M, with tnew decremented and saturating at 0.
REQ-016 E←bubble (dest 0) when stall=1; otherwise E←decode(ir_d).
REQ-017 SHALL assert stall combinationally when a D-stage register r≠0 with Tuse T matches a non-bubble dest in E with tnew_E>T, or in M with tnew_M>T.
REQ-018 SHALL stall a D-stage md/mf/mt while E holds md or busy_cnt≠0.
REQ-019 SHALL load busy_cnt with 5 (mult/multu) or 10 (div/divu) on the edge where md leaves E; otherwise decrement while ≠0.
REQ-020 SHALL compute D-stage selects by priority E (tnew 0, src pc8 → 4), then M (tnew 0: pc8 → 2, alu → 3), then W (→1), else 0.
REQ-021 SHALL compute E-stage selects by priority M then W, same encodings; rtm_sel is 1 on a W match, else 0.
REQ-022 SHALL never forward for register 0 or a bubble.
REQ-023 SHALL drive a3_w from W.dest.
REQ-024 SHALL leave all selects independent of stall.

Reset
REQ-025 On reset, all shadow stages SHALL become bubbles and busy_cnt SHALL be 0, so stall=0, all selects=0 and a3_w=0, including mid md-busy.

Structure
REQ-026 A shared package SHALL hold: opcode/funct constants, class enum, bypass-select encodings, Tnew/Tuse constants, and MD latencies 5/10.
REQ-027 SHALL contain one combinational sub-module instr_decode: ir → {class, dest, tnew, src, rs/rt use, Tuse}; the top SHALL instantiate it for D only.

Verification
REQ-028 lw $1,0($0); addu $2,$1,$1 → stall=1 for exactly 1 cycle; then with addu in E and lw in W, rse_sel=rte_sel=1.
REQ-029 ori $3,$0,5; beq $3,$3 → stall=1 for 1 cycle; then rsd_sel=rtd_sel=3.
REQ-030 jal; jr $31 in delay slot → no stall, rsd_sel=4; when jr follows one instruction later → rsd_sel=2.
REQ-031 mult $1,$2; mflo $4 → stall=1 for 6 consecutive cycles; div → 11 cycles.
REQ-032 lw $5; sw $5,0($0) → no stall, rtm_sel=1 when sw is in M; addu $0,$1,$1; addu $2,$0,$0 → all selects 0.
REQ-033 reset pulse asserted 3 cycles into a div stall → stall=0, a3_w=0 immediately, and no stall after reset releases.
